serial_sub_seq: RTL and testbench

SERIAL_SUB_SEQ -- requirements
Module: serial_sub_seq

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_seq_bytesub.sv | 17 +
 rtl/serial_sub_seq.sv | 119 +++++++++++
 tb/tb_serial_sub_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the byte-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_seq_bytesub.sv
// 8-bit subtractor with borrow in/out; the only arithmetic in the serial subtractor.
module byteSub (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic [7:0] D,
    output logic       Bout
);

    logic [8:0] res;

    // The 9th bit of the widened difference is the borrow out.
    assign res  = {1'b0, A} - {1'b0, B} - {8'd0, Bin};
    assign D    = res[7:0];
    assign Bout = res[8];

endmodule

// File: rtl/serial_sub_seq.sv
// Multi-byte subtractor that time-multiplexes one byteSub, LSB byte first.
module serial_sub_seq
    import serial_sub_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF,
    localparam int W     = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         zero
);

    state_t state_q, state_d;

    logic [W-1:0]      a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [NBYTES-1:0] sel_q, sel_d;  // one-hot byte index, avoids an index adder
    logic              brw_q, brw_d;

    logic [7:0] byte_a, byte_b, byte_d;
    logic       byte_bout;
    logic       last;

    assign last = sel_q[NBYTES-1];

    always_comb begin
        byte_a = '0;
        byte_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (sel_q[i]) begin
                byte_a = byte_a | a_q[8*i +: 8];
                byte_b = byte_b | b_q[8*i +: 8];
            end
        end
    end

    byteSub u_bsub (
        .A    (byte_a),
        .B    (byte_b),
        .Bin  (brw_q),
        .D    (byte_d),
        .Bout (byte_bout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SUB;
            SUB:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SUB:     busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sel_d  = sel_q;
        brw_d  = brw_q;
        diff_d = diff_q;
        if (state_q == IDLE && start) begin
            a_d   = a;
            b_d   = b;
            sel_d = {{(NBYTES-1){1'b0}}, 1'b1};
            brw_d = 1'b0;
        end else if (state_q == SUB) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (sel_q[i]) diff_d[8*i +: 8] = byte_d;
            end
            brw_d = byte_bout;
            sel_d = {sel_q[NBYTES-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= {{(NBYTES-1){1'b0}}, 1'b1};
            brw_q  <= 1'b0;
            diff_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sel_q  <= sel_d;
            brw_q  <= brw_d;
            diff_q <= diff_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = brw_q;
    assign zero   = (diff_q == '0);

endmodule

// File: tb/tb_serial_sub_seq.sv
// Directed bench for serial_sub_seq at the default width of 4 bytes.
module tb_serial_sub_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow, zero;
    logic [W-1:0] diff;

    int ntests = 0;
    int nfail  = 0;
    int done_cnt = 0;

    serial_sub_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full operation from IDLE: start in cycle c, done must appear in cycle c+5 only.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb);
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy1"}, 64'(busy), 64'd1);
        repeat (3) tick();
        chk({tag, ".nodone4"}, 64'(done), 64'd0);
        tick();
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".diff"}, 64'(diff), 64'(ed));
        chk({tag, ".borrow"}, 64'(borrow), 64'(eb));
        chk({tag, ".zero"}, 64'(zero), 64'(ed == '0));
        tick();
        chk({tag, ".idle"}, 64'({busy, done}), 64'd0);
        chk({tag, ".hold"}, 64'(diff), 64'(ed));
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.diff", 64'(diff), 64'd0);
        chk("rst.borrow", 64'(borrow), 64'd0);
        chk("rst.zero", 64'(zero), 64'd1);

        run_op("v5m3", 32'h00000005, 32'h00000003, 32'h00000002, 1'b0);
        run_op("v0m1", 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1);
        run_op("v100m1", 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0);
        run_op("veq", 32'h12345678, 32'h12345678, 32'h00000000, 1'b0);
        run_op("vmsb", 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0);
        run_op("vneg", 32'h00000001, 32'h80000000, 32'h80000001, 1'b1);
        run_op("vmix", 32'hA5B6C7D8, 32'h1F2E3D4C, 32'h8688 * 32'h0 + 32'h8688_8A8C, 1'b0);

        // Second start two cycles into an operation, and a start during DONE, are ignored.
        dc = done_cnt;
        a = 32'h00001000; b = 32'h00000001; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 32'h00000000; b = 32'h00000007; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("ign.done", 64'(done), 64'd1);
        chk("ign.diff", 64'(diff), 64'h00000FFF);
        chk("ign.borrow", 64'(borrow), 64'd0);
        a = 32'h00000003; b = 32'h00000009; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign.dnbusy", 64'(busy), 64'd0);
        chk("ign.dnhold", 64'(diff), 64'h00000FFF);
        repeat (6) tick();
        chk("ign.onedone", 64'(done_cnt - dc), 64'd1);
        chk("ign.stillidle", 64'(busy), 64'd0);

        // Reset in the third SUB cycle aborts with no done pulse.
        dc = done_cnt;
        a = 32'hFFFFFFFF; b = 32'h00000001; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.diff", 64'(diff), 64'd0);
        chk("abort.borrow", 64'(borrow), 64'd0);
        // Reset wins over a simultaneous start.
        a = 32'h00000002; b = 32'h00000003; start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rstpri.busy", 64'(busy), 64'd0);
        repeat (6) tick();
        chk("abort.nodone", 64'(done_cnt - dc), 64'd0);
        run_op("postrst", 32'h00000009, 32'h00000004, 32'h00000005, 1'b0);

        // Back-to-back: start in the IDLE cycle right after DONE.
        a = 32'h00010000; b = 32'h00000001; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("b2b1.done", 64'(done), 64'd1);
        chk("b2b1.diff", 64'(diff), 64'h0000FFFF);
        tick();
        a = 32'h00000010; b = 32'h00000020; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b2.busy", 64'(busy), 64'd1);
        repeat (3) tick();
        chk("b2b2.nodone", 64'(done), 64'd0);
        tick();
        chk("b2b2.done", 64'(done), 64'd1);
        chk("b2b2.diff", 64'(diff), 64'hFFFFFFF0);
        chk("b2b2.borrow", 64'(borrow), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
